console_tx_ctrl: RTL and testbench
==================================

# console_tx_ctrl

Console output controller. It buffers the character writes the core issues on `console_we`/`console_wdata` in a FIFO and drains them as 8-N-1 UART frames on a single serial line. It sits between `bbq` and the board's UART pin, or the bench's serial monitor. It lets the core write console bytes at full rate and reports buffer overflow and drain status, so a bench can wait for output to finish before ending a run.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: the only clock. All logic is rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `console_we`, input, 1: write strobe from the core, one byte per high cycle.
- `console_wdata`, input, XLEN (32): write data. Only bits [7:0] are used; [31:8] are ignored.
- `tx`, output, 1: serial line, idle high. Registered.
- `busy`, output, 1: high while a frame is on the line.
- `overflow`, output, 1: sticky. Set when a write is dropped.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: number of bytes queued, not counting the byte in flight.
- `drained`, output, 1: high when the FIFO is empty and the FSM is IDLE.

## Operation

- FIFO: circular buffer with read and write pointers that wrap at `FIFO_DEPTH`, plus a separate count register.
- Push:
  - A push happens on an edge where `console_we`=1 and `fifo_count` < `FIFO_DEPTH`.
  - If `fifo_count` == `FIFO_DEPTH` at that edge, the byte is dropped and `overflow` is set. This holds even if a pop occurs on the same edge.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop a byte into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send 8 bits, LSB first, each for `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7. After bit 7, go to PARITY or STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On its last cycle, if the FIFO is non-empty, pop the next byte and go directly to START, with no idle gap. Otherwise go to IDLE.
- Bit timer: counts down from `CLKS_PER_BIT`-1 to 0 and reloads on each bit boundary. Its width is $clog2(`CLKS_PER_BIT`).
- `busy` is 1 in every state except IDLE.
- `overflow` is cleared only by `reset`.

## Timing

- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, `drained`=1. The FIFO pointers are zeroed and the FSM is in IDLE.
- Reset asserted mid-frame:
  - The frame is aborted and `tx` is 1 in the cycle after the reset edge.
  - Queued bytes are discarded.
  - A `console_we` sampled on the reset edge is ignored.
- Latency into an empty, idle block:
  - A write sampled at edge N gives `fifo_count`=1 after N.
  - The pop happens at edge N+1.
  - `tx` goes low after edge N+1 and `busy` goes high at the same time.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- `busy` falls on the edge that ends STOP when the FIFO is empty. `drained` rises on that same edge.
- There is no backpressure to the core. The core is never stalled.

## Configuration

- `CONSOLE_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - One even-parity bit (XOR of the 8 data bits) is sent for `CLKS_PER_BIT` cycles between DATA and STOP.
- Not defined: there is no parity state, and the frame is 8-N-1.

## Test plan

- Single byte: `CLKS_PER_BIT`=4, write 0x55 → `tx` over 40 cycles reads 0,1,0,1,0,1,0,1,0,1, with each bit held 4 cycles. `busy` is high for exactly 40 cycles, then `drained`=1.
- Back-to-back: write 0x41, 0x42, 0x43 on consecutive cycles → 120 contiguous busy cycles with no idle gap. Bytes are received in order. `fifo_count` peaks at 2.
- Overflow: `FIFO_DEPTH`=4, write 6 bytes on consecutive cycles starting from idle → the first 5 bytes are transmitted, the 6th is dropped, and `overflow`=1 from the 6th write edge until reset.
- Upper bits ignored: write 0xFFFFFF41 → the frame carries 0x41.
- Reset mid-frame: assert `reset` during DATA bit 3 with 2 bytes queued → the next cycle shows `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0. No further frames are sent.
- Parity (macro defined): write 0x07 → the parity bit is 1 and the frame is 44 cycles at `CLKS_PER_BIT`=4. Write 0x03 → the parity bit is 0.

Source files
------------

// File: rtl/console_tx_ctrl.sv
// console_tx_ctrl
// Buffers console byte writes from the core in a small FIFO and drains them
// as 8-N-1 UART frames (8-E-1 when CONSOLE_TX_PARITY_EN is defined).
// The core is never stalled; writes into a full FIFO are dropped and flagged.
//
// Optional feature macro: CONSOLE_TX_PARITY_EN (adds one even-parity bit
// between the data bits and the stop bit).
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high
//   console_we     in   one byte write per high cycle
//   console_wdata  in   [31:0], only [7:0] are queued
//   tx             out  serial line, idle high, registered
//   busy           out  frame on the line (FSM not idle)
//   overflow       out  sticky, a write was dropped on a full FIFO
//   fifo_count     out  bytes queued, excluding the byte in flight
//   drained        out  FIFO empty and FSM idle
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high, waiting for a queued byte
// START  | start bit (tx=0) for one bit time
// DATA   | 8 data bits, LSB first, one bit time each
// PARITY | even parity over the data byte (parity build only)
// STOP   | stop bit (tx=1); chains straight into START if more is queued

module console_tx_ctrl #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          console_we,
   input  logic [31:0]                   console_wdata,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          drained
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef CONSOLE_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;

   logic [TW-1:0]     r_timer;
   logic [2:0]        r_bit_idx;
   logic [7:0]        r_shift;
   logic              r_tx;

   logic [TW-1:0]     w_timer_nxt;
   logic [2:0]        w_bit_idx_nxt;
   logic [7:0]        w_shift_nxt;
   logic              w_tx_nxt;
   logic              w_pop;

`ifdef CONSOLE_TX_PARITY_EN
   logic              r_parity;
   logic              w_parity_nxt;
`endif

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_bit_done;
   logic [7:0]        w_head;
   logic              w_unused;

   assign w_full     = (r_count == DEPTH_C);
   assign w_empty    = (r_count == '0);
   // Full is judged on the count before this edge, so a same-edge pop
   // does not rescue a write into a full FIFO.
   assign w_push     = console_we && !w_full;
   assign w_bit_done = (r_timer == '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_unused   = ^console_wdata[31:8];

   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_timer_nxt   = r_timer - 1'b1;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
`ifdef CONSOLE_TX_PARITY_EN
      w_parity_nxt  = r_parity;
`endif

      case (r_state)
         S_IDLE: begin
            w_timer_nxt = TIMER_LOAD;
            if (!w_empty) begin
               w_pop         = 1'b1;
               w_shift_nxt   = w_head;
               w_bit_idx_nxt = 3'd0;
`ifdef CONSOLE_TX_PARITY_EN
               w_parity_nxt  = ^w_head;
`endif
               w_state_nxt   = S_START;
            end
         end
         S_START: begin
            if (w_bit_done) begin
               w_timer_nxt = TIMER_LOAD;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_done) begin
               w_timer_nxt = TIMER_LOAD;
               if (r_bit_idx == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
               end
            end
         end
`ifdef CONSOLE_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_done) begin
               w_timer_nxt = TIMER_LOAD;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_bit_done) begin
               w_timer_nxt = TIMER_LOAD;
               // Chain the next queued byte with no idle gap on the line.
               if (!w_empty) begin
                  w_pop         = 1'b1;
                  w_shift_nxt   = w_head;
                  w_bit_idx_nxt = 3'd0;
`ifdef CONSOLE_TX_PARITY_EN
                  w_parity_nxt  = ^w_head;
`endif
                  w_state_nxt   = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_timer_nxt = TIMER_LOAD;
            w_state_nxt = S_IDLE;
         end
      endcase

      // tx is registered from the next state so it changes on the same
      // edge as the state it belongs to.
      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef CONSOLE_TX_PARITY_EN
         S_PARITY: w_tx_nxt = w_parity_nxt;
`endif
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_timer    <= TIMER_LOAD;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'd0;
         r_tx       <= 1'b1;
`ifdef CONSOLE_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_tx_nxt;
`ifdef CONSOLE_TX_PARITY_EN
         r_parity  <= w_parity_nxt;
`endif
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (console_we && w_full) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= console_wdata[7:0];
   end

   assign tx         = r_tx;
   assign busy       = (r_state != S_IDLE);
   assign overflow   = r_overflow;
   assign fifo_count = r_count;
   assign drained    = w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_console_tx_ctrl.sv
module tb_console_tx_ctrl;

   localparam int C     = 4;
   localparam int DEPTH = 4;
`ifdef CONSOLE_TX_PARITY_EN
   localparam int FL = 11 * C;
`else
   localparam int FL = 10 * C;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        console_we;
   logic [31:0] console_wdata;
   logic        tx;
   logic        busy;
   logic        overflow;
   logic [2:0]  fifo_count;
   logic        drained;

   always #5 clk = ~clk;

   console_tx_ctrl #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .console_we    (console_we),
      .console_wdata (console_wdata),
      .tx            (tx),
      .busy          (busy),
      .overflow      (overflow),
      .fifo_count    (fifo_count),
      .drained       (drained)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   logic        cap [0:511];
   logic [31:0] wr  [0:7];
   int          busy_cnt, first_busy, last_busy, peak, ovf_first, cnt_at1;
   logic        drained_end, timed_out;

   // Drives wr[0..n_wr-1] on consecutive cycles and records the line until
   // busy falls after all writes. Samples and drives on the falling edge.
   task automatic run(input int n_wr);
      logic seen;
      busy_cnt = 0; first_busy = -1; last_busy = -1; peak = 0;
      ovf_first = -1; cnt_at1 = -1; drained_end = 1'b0; timed_out = 1'b1;
      seen = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         if (cyc == 1) cnt_at1 = int'(fifo_count);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         if (overflow && ovf_first < 0) ovf_first = cyc;
         if (busy) begin
            if (!seen) first_busy = cyc;
            seen = 1'b1;
            if (busy_cnt < 512) cap[busy_cnt] = tx;
            busy_cnt++;
            last_busy = cyc;
         end else if (seen && cyc >= n_wr) begin
            drained_end = drained;
            timed_out = 1'b0;
            break;
         end
         if (cyc < n_wr) begin
            console_we = 1'b1;
            console_wdata = wr[cyc];
         end else begin
            console_we = 1'b0;
         end
      end
      console_we = 1'b0;
   endtask

   function automatic logic [7:0] decode(input int j);
      logic [7:0] d;
      for (int b = 0; b < 8; b++) d[b] = cap[j*FL + C*(1+b) + C/2];
      return d;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [10:0] ev;
      int          mism;
      int          bcnt;

      reset = 1'b1;
      console_we = 1'b0;
      console_wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_overflow", overflow, 0);
      check("reset_count", fifo_count, 0);
      check("reset_drained", drained, 1);
      reset = 1'b0;

      // Single byte 0x55
      wr[0] = 32'h55;
      run(1);
      check("single_timeout", timed_out, 0);
      check("single_count_after_write", cnt_at1, 1);
      check("single_first_busy_cycle", first_busy, 2);
      check("single_busy_len", busy_cnt, FL);
      check("single_drained", drained_end, 1);
      check("single_count_end", fifo_count, 0);
`ifdef CONSOLE_TX_PARITY_EN
      ev = 11'b10010101010;
`else
      ev = 11'b01010101010;
`endif
      mism = 0;
      for (int i = 0; i < FL; i++) if (cap[i] !== ev[i/C]) mism++;
      check("single_tx_pattern_mismatches", mism, 0);

      // Back-to-back 0x41 0x42 0x43
      wr[0] = 32'h41; wr[1] = 32'h42; wr[2] = 32'h43;
      run(3);
      check("b2b_timeout", timed_out, 0);
      check("b2b_busy_len", busy_cnt, 3*FL);
      check("b2b_contiguous", last_busy - first_busy + 1, 3*FL);
      check("b2b_peak_count", peak, 2);
      check("b2b_byte0", decode(0), 8'h41);
      check("b2b_byte1", decode(1), 8'h42);
      check("b2b_byte2", decode(2), 8'h43);
      check("b2b_drained", drained_end, 1);

      // Overflow: 6 writes into depth 4
      for (int i = 0; i < 6; i++) wr[i] = 32'h10 + i;
      run(6);
      check("ovf_timeout", timed_out, 0);
      check("ovf_first_cycle", ovf_first, 6);
      check("ovf_busy_len", busy_cnt, 5*FL);
      for (int j = 0; j < 5; j++) check($sformatf("ovf_byte%0d", j), decode(j), 8'h10 + j);
      repeat (20) @(negedge clk);
      check("ovf_sticky", overflow, 1);

      // Upper data bits ignored
      wr[0] = 32'hFFFFFF41;
      run(1);
      check("upper_busy_len", busy_cnt, FL);
      check("upper_byte", decode(0), 8'h41);

`ifdef CONSOLE_TX_PARITY_EN
      wr[0] = 32'h07;
      run(1);
      check("par07_busy_len", busy_cnt, 44);
      check("par07_byte", decode(0), 8'h07);
      check("par07_parity", cap[9*C + C/2], 1);
      wr[0] = 32'h03;
      run(1);
      check("par03_byte", decode(0), 8'h03);
      check("par03_parity", cap[9*C + C/2], 0);
`endif

      // Reset during DATA bit 3 with two bytes queued
      console_we = 1'b1; console_wdata = 32'hF7;
      @(negedge clk); console_wdata = 32'h11;
      @(negedge clk); console_wdata = 32'h22;
      @(negedge clk); console_we = 1'b0;
      repeat (16) @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_count", fifo_count, 2);
      check("mid_tx_bit3", tx, 0);
      check("mid_overflow_still_set", overflow, 1);
      reset = 1'b1;
      console_we = 1'b1; console_wdata = 32'h33;
      @(negedge clk);
      reset = 1'b0;
      console_we = 1'b0;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drained", drained, 1);
      bcnt = 0;
      for (int i = 0; i < 3*FL; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
      end
      check("rst_no_more_frames", bcnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
